// File: rtl/dense_mac_layer.sv
// dense_mac_layer: fully-connected layer producer.
//   layer_out[n] = biases[n] + sum_k(inputs[k] * W[n][k])
// Weights stream from an external synchronous ROM (1-cycle read latency),
// UNROLL_FACTOR signed lanes per word. Word n*NUM_CHUNKS + c carries
// W[n][c*UNROLL_FACTOR +: UNROLL_FACTOR], lane i in bits [i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH].
// Each neuron takes NUM_CHUNKS+1 cycles: bias load + read issue, overlapped
// read/accumulate, then a drain cycle that writes the result.
// Flat vector ports: element k of inputs/biases/layer_out sits at [k*width +: width].
//
// Build option: define DENSE_ACC_SAT_EN to make every accumulator update clamp
// to the signed BIAS_WIDTH range and to raise the sticky sat_seen flag.
// Without it the accumulator wraps modulo 2^BIAS_WIDTH and sat_seen is tied 0.

module dense_mac_layer #(
  parameter int INPUT_SIZE    = 512,
  parameter int OUTPUT_SIZE   = 512,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int BIAS_WIDTH    = 32,
  parameter int UNROLL_FACTOR = 8,
  localparam int NUM_CHUNKS   = INPUT_SIZE / UNROLL_FACTOR,
  localparam int AW           = $clog2(OUTPUT_SIZE * NUM_CHUNKS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   done,
  output logic                                   busy,
  input  logic [INPUT_SIZE*WEIGHTS_WIDTH-1:0]    inputs,
  input  logic [OUTPUT_SIZE*BIAS_WIDTH-1:0]      biases,
  output logic                                   w_rd_en,
  output logic [AW-1:0]                          w_addr,
  input  logic [UNROLL_FACTOR*WEIGHTS_WIDTH-1:0] w_rdata,
  output logic [OUTPUT_SIZE*BIAS_WIDTH-1:0]      layer_out,
  output logic                                   sat_seen
);

  // Counter widths: neuron index and per-neuron cycle index (0..NUM_CHUNKS).
  localparam int NW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int CW = $clog2(NUM_CHUNKS + 1);

  localparam logic [NW-1:0] LAST_NEURON = NW'(OUTPUT_SIZE - 1);
  localparam logic [CW-1:0] DRAIN_CYCLE = CW'(NUM_CHUNKS);
  localparam logic [CW-1:0] LAST_READ   = CW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                            r_state;
  logic [NW-1:0]                     r_neuron;
  logic [CW-1:0]                     r_cycle;
  logic signed [BIAS_WIDTH-1:0]      r_acc;
  logic                              r_done;
  logic                              r_busy;
  logic                              r_rd_en;
  logic [AW-1:0]                     r_addr;
  logic [OUTPUT_SIZE*BIAS_WIDTH-1:0] r_layer_out;

  logic [CW-1:0]                     w_chunk;
  logic signed [2*WEIGHTS_WIDTH-1:0] w_prod;
  logic signed [BIAS_WIDTH-1:0]      w_lane_sum;
  logic signed [BIAS_WIDTH-1:0]      w_acc_next;
  logic signed [BIAS_WIDTH-1:0]      w_bias;
  logic                              w_accepted;
  logic                              w_accum;
  logic                              w_drain;

  // The ROM word on w_rdata in cycle c belongs to chunk c-1; cycle 0 never
  // consumes it, so pin the index to 0 there to stay inside the input vector.
  assign w_chunk    = (r_cycle == '0) ? '0 : r_cycle - 1'b1;
  assign w_bias     = $signed(biases[int'(r_neuron)*BIAS_WIDTH +: BIAS_WIDTH]);
  assign w_accepted = (r_state == S_IDLE) && start;
  assign w_accum    = (r_state == S_RUN) && (r_cycle != '0);
  assign w_drain    = (r_state == S_RUN) && (r_cycle == DRAIN_CYCLE);

  // Lane-sum of the current ROM word against its activation chunk.
  always_comb begin
    // NOTE: give every always_comb output a value before any branch or loop;
    // a path that leaves one unassigned would infer a latch.
    w_prod     = '0;
    w_lane_sum = '0;
    for (int i = 0; i < UNROLL_FACTOR; i++) begin
      w_prod = $signed(w_rdata[i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH])
             * $signed(inputs[(int'(w_chunk)*UNROLL_FACTOR + i)*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]);
      w_lane_sum = w_lane_sum + BIAS_WIDTH'(w_prod);
    end
  end

`ifdef DENSE_ACC_SAT_EN
  localparam logic signed [BIAS_WIDTH-1:0] ACC_MAX = {1'b0, {(BIAS_WIDTH-1){1'b1}}};
  localparam logic signed [BIAS_WIDTH-1:0] ACC_MIN = {1'b1, {(BIAS_WIDTH-1){1'b0}}};

  logic signed [BIAS_WIDTH:0] w_sum_wide;
  logic                       w_clamp;
  logic                       r_sat;

  // Accumulator update with one guard bit; clamp when the guard disagrees with the sign.
  always_comb begin
    w_sum_wide = {r_acc[BIAS_WIDTH-1], r_acc} + {w_lane_sum[BIAS_WIDTH-1], w_lane_sum};
    w_clamp    = (w_sum_wide[BIAS_WIDTH] != w_sum_wide[BIAS_WIDTH-1]);
    if (!w_clamp) begin
      w_acc_next = w_sum_wide[BIAS_WIDTH-1:0];
    end else if (w_sum_wide[BIAS_WIDTH]) begin
      w_acc_next = ACC_MIN;
    end else begin
      w_acc_next = ACC_MAX;
    end
  end

  // Sticky saturation flag, cleared by reset or by an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_accepted) begin
      r_sat <= 1'b0;
    end else if (w_accum && w_clamp) begin
      r_sat <= 1'b1;
    end
  end

  assign sat_seen = r_sat;
`else
  // Wrapping accumulator update (modulo 2^BIAS_WIDTH).
  always_comb begin
    w_acc_next = r_acc + w_lane_sum;
  end

  assign sat_seen = 1'b0;
`endif

  // Control FSM: sequences neurons and chunks and pre-computes the registered
  // ROM strobe/address for the following cycle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge regardless of statement order.
    if (rst) begin
      r_state  <= S_IDLE;
      r_neuron <= '0;
      r_cycle  <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_neuron <= '0;
            r_cycle  <= '0;
            r_rd_en  <= 1'b1;
            r_addr   <= '0;
          end
        end

        S_RUN: begin
          if (r_cycle == '0) begin
            r_acc <= w_bias;
          end else if (r_cycle != DRAIN_CYCLE) begin
            r_acc <= w_acc_next;
          end

          if (r_cycle == DRAIN_CYCLE) begin
            r_cycle <= '0;
            if (r_neuron == LAST_NEURON) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_rd_en <= 1'b0;
            end else begin
              r_neuron <= r_neuron + 1'b1;
              r_rd_en  <= 1'b1;
              r_addr   <= r_addr + 1'b1;
            end
          end else begin
            r_cycle <= r_cycle + 1'b1;
            // The cycle after the last read is the drain cycle: no read there.
            if (r_cycle == LAST_READ) begin
              r_rd_en <= 1'b0;
            end else begin
              r_rd_en <= 1'b1;
              r_addr  <= r_addr + 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_addr  <= '0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Result bank: neuron n is written only in its own drain cycle.
  always_ff @(posedge clk) begin
    // NOTE: the result bank is cleared on reset because downstream logic reads
    // it as a defined value; plain storage arrays normally skip reset.
    if (rst) begin
      r_layer_out <= '0;
    end else if (w_drain) begin
      r_layer_out[int'(r_neuron)*BIAS_WIDTH +: BIAS_WIDTH] <= w_acc_next;
    end
  end

  assign done      = r_done;
  assign busy      = r_busy;
  assign w_rd_en   = r_rd_en;
  assign w_addr    = r_addr;
  assign layer_out = r_layer_out;

endmodule
